// File: rtl/dcache_wb.sv
// Direct-mapped, one-word-per-frame write-back data cache with a halt-triggered flush.
// Optional DCACHE_HITCOUNT_EN: net hit counter, written to 0x3100 after the flush.
module dcache_wb #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait,
    output logic [2:0]  dbg_state_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    // Memory handshake: a request (dREN or dWEN) is held with stable daddr/dstore
    // until a cycle with dwait=0; the transfer completes at that cycle's rising edge.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FETCH = 3'd2,
        FLUSH = 3'd3,
        COUNT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q;
    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic [IDX_W-1:0]   flush_idx_q;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req;
    logic               tag_match;
    logic               victim_dirty;
    logic               flush_dirty;
    logic               fill_en;
    logic               wr_hit;
    logic               unused_addr_lsb;

    assign req_idx         = dmemaddr[2 +: IDX_W];
    assign req_tag         = dmemaddr[31 -: TAG_W];
    assign req             = dmemREN | dmemWEN;
    assign tag_match       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty    = valid_q[req_idx] && dirty_q[req_idx];
    assign flush_dirty     = valid_q[flush_idx_q] && dirty_q[flush_idx_q];
    assign fill_en         = (state_q == FETCH) && !dwait;
    assign wr_hit          = dhit && dmemWEN;
    assign unused_addr_lsb = ^dmemaddr[1:0];
    assign dbg_state_o     = state_q;

`ifdef DCACHE_HITCOUNT_EN
    logic signed [31:0] hit_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q <= '0;
        end else if (dhit) begin
            hit_cnt_q <= hit_cnt_q + 32'sd1;
        end else if (fill_en) begin
            hit_cnt_q <= hit_cnt_q - 32'sd1;
        end
    end
`endif

    // Halt outranks a pending request, so a hit is never reported alongside it.
    always_comb begin
        dhit     = (state_q == IDLE) && !halt && req && tag_match;
        dmemload = dhit ? data_q[req_idx] : 32'h0;
    end

    always_comb begin
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = 32'h0;
        dstore  = 32'h0;
        flushed = 1'b0;
        case (state_q)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[req_idx], req_idx, 2'b00};
                dstore = data_q[req_idx];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
            end
            FLUSH: begin
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_q[flush_idx_q], flush_idx_q, 2'b00};
                    dstore = data_q[flush_idx_q];
                end
            end
            COUNT: begin
`ifdef DCACHE_HITCOUNT_EN
                dWEN   = 1'b1;
                daddr  = 32'h0000_3100;
                dstore = $unsigned(hit_cnt_q);
`endif
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            flush_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        state_q     <= FLUSH;
                        flush_idx_q <= '0;
                    end else if (req) begin
                        if (tag_match) begin
                            if (dmemWEN) dirty_q[req_idx] <= 1'b1;
                        end else if (victim_dirty) begin
                            state_q <= WB;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (!dwait) state_q <= FETCH;
                end
                FETCH: begin
                    if (!dwait) begin
                        valid_q[req_idx] <= 1'b1;
                        dirty_q[req_idx] <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                FLUSH: begin
                    // Clean frames advance immediately; dirty ones wait for the write to finish.
                    if (!flush_dirty || !dwait) begin
                        if (flush_dirty) dirty_q[flush_idx_q] <= 1'b0;
                        if (flush_idx_q == LAST_IDX) begin
                            state_q <= COUNT;
                        end else begin
                            flush_idx_q <= flush_idx_q + 1'b1;
                        end
                    end
                end
                COUNT: begin
`ifdef DCACHE_HITCOUNT_EN
                    if (!dwait) state_q <= DONE;
`else
                    state_q <= DONE;
`endif
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag/data need no reset: valid gates them, and fills only land when the FETCH completes.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[req_idx] <= dload;
            tag_q[req_idx]  <= req_tag;
        end else if (wr_hit) begin
            data_q[req_idx] <= dmemstore;
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb (SETS=16): fills, write hits, writebacks, flush, reset abort.
module tb_dcache_wb;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_COUNT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef DCACHE_HITCOUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = 32'h0;
    logic [31:0] dmemstore = 32'h0;
    logic [31:0] dload = 32'h0;
    logic        dwait = 1'b1;
    logic [31:0] dmemload;
    logic        dhit;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int cnt = 0;
    bit both_seen = 1'b0;

    logic [31:0] mem [logic [31:0]];
    bit          log_we[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    dcache_wb #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait), .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Memory responder: holds dwait=1 for 'lat' cycles of a request, then completes and logs it.
    initial begin
        forever begin
            @(negedge CLK);
            if (dREN && dWEN) both_seen = 1'b1;
            if (!nRST) begin
                dwait = 1'b1;
                cnt = 0;
            end else if (dREN || dWEN) begin
                if (cnt >= lat) begin
                    dwait = 1'b0;
                    cnt = 0;
                    log_we.push_back(dWEN);
                    log_addr.push_back(daddr);
                    if (dWEN) begin
                        log_data.push_back(dstore);
                        mem[daddr] = dstore;
                    end else begin
                        dload = mem.exists(daddr) ? mem[daddr] : 32'h0;
                        log_data.push_back(dload);
                    end
                end else begin
                    dwait = 1'b1;
                    cnt++;
                end
            end else begin
                dwait = 1'b1;
                cnt = 0;
            end
        end
    end

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output bit ok, output int cyc);
        @(posedge CLK);
        #1;
        dmemREN = ren;
        dmemWEN = wen;
        dmemaddr = addr;
        dmemstore = wdata;
        ok = 1'b0;
        cyc = 0;
        rdata = 32'h0;
        while (cyc < 200) begin
            @(negedge CLK);
            if (dhit) begin
                rdata = dmemload;
                ok = 1'b1;
                break;
            end
            cyc++;
        end
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic test_reset();
        dmemREN = 1'b1;
        dmemaddr = 32'h40;
        repeat (2) @(negedge CLK);
        checks++;
        if ({dREN, dWEN, dhit, flushed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected 0000", {dREN, dWEN, dhit, flushed});
        end
        checks++;
        if (daddr !== 32'h0 || dstore !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got daddr=%h dstore=%h expected 0", daddr, dstore);
        end
        checks++;
        if (dmemload !== 32'h0) begin
            failures++;
            $display("FAIL reset_load: got %h expected 0", dmemload);
        end
        checks++;
        if (dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
        end
        dmemREN = 1'b0;
        #2 nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (dhit !== 1'b0 || dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL post_reset: got dhit=%b state=%0d expected 0/%0d", dhit, dbg_state, S_IDLE);
        end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        bit ok;
        int cyc;
        lat = 3;
        mem[32'h40] = 32'hDEADBEEF;
        clear_log();
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, ok, cyc);
        checks++;
        if (!ok || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL cold_read: got ok=%0d data=%h expected 1/deadbeef", ok, rd);
        end
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL cold_latency: got %0d expected 5", cyc);
        end
        checks++;
        if (log_we.size() != 1) begin
            failures++;
            $display("FAIL cold_traffic: got %0d transfers expected 1", log_we.size());
        end else begin
            checks++;
            if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h40) begin
                failures++;
                $display("FAIL cold_fetch: got we=%0d addr=%h expected 0/00000040", log_we[0], log_addr[0]);
            end
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd;
        bit ok;
        int cyc;
        clear_log();
        access(1'b0, 1'b1, 32'h40, 32'h11111111, rd, ok, cyc);
        checks++;
        if (!ok || cyc != 0) begin
            failures++;
            $display("FAIL write_hit: got ok=%0d cycles=%0d expected 1/0", ok, cyc);
        end
        checks++;
        if (log_we.size() != 0) begin
            failures++;
            $display("FAIL write_hit_traffic: got %0d transfers expected 0", log_we.size());
        end
    endtask

    task automatic test_writeback();
        logic [31:0] rd;
        bit ok;
        int cyc;
        mem[32'h440] = 32'h22222222;
        clear_log();
        access(1'b1, 1'b0, 32'h440, 32'h0, rd, ok, cyc);
        checks++;
        if (!ok || rd !== 32'h22222222) begin
            failures++;
            $display("FAIL wb_read: got ok=%0d data=%h expected 1/22222222", ok, rd);
        end
        checks++;
        if (log_we.size() != 2) begin
            failures++;
            $display("FAIL wb_traffic: got %0d transfers expected 2", log_we.size());
        end else begin
            checks++;
            if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h40 || log_data[0] !== 32'h11111111) begin
                failures++;
                $display("FAIL wb_write: got we=%0d addr=%h data=%h expected 1/00000040/11111111",
                         log_we[0], log_addr[0], log_data[0]);
            end
            checks++;
            if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h440) begin
                failures++;
                $display("FAIL wb_fetch: got we=%0d addr=%h expected 0/00000440", log_we[1], log_addr[1]);
            end
        end
    endtask

    task automatic test_read_write_both();
        logic [31:0] rd;
        bit ok;
        int cyc;
        mem[32'h80] = 32'h33333333;
        clear_log();
        access(1'b1, 1'b1, 32'h80, 32'h44444444, rd, ok, cyc);
        checks++;
        if (!ok || log_we.size() != 1) begin
            failures++;
            $display("FAIL rw_miss: got ok=%0d transfers=%0d expected 1/1", ok, log_we.size());
        end else begin
            checks++;
            if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h80) begin
                failures++;
                $display("FAIL rw_fetch: got we=%0d addr=%h expected 0/00000080", log_we[0], log_addr[0]);
            end
        end
        access(1'b1, 1'b0, 32'h80, 32'h0, rd, ok, cyc);
        checks++;
        if (!ok || cyc != 0 || rd !== 32'h44444444) begin
            failures++;
            $display("FAIL rw_readback: got ok=%0d cycles=%0d data=%h expected 1/0/44444444", ok, cyc, rd);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        bit ok;
        bit ok2;
        int cyc;
        int n;
        lat = 1;
        access(1'b0, 1'b1, 32'h14, 32'h55555555, rd, ok, cyc);
        access(1'b0, 1'b1, 32'h3C, 32'h66666666, rd, ok2, cyc);
        checks++;
        if (!ok || !ok2) begin
            failures++;
            $display("FAIL flush_setup: got ok=%0d/%0d expected 1/1", ok, ok2);
        end
        clear_log();
        @(posedge CLK);
        #1 halt = 1'b1;
        n = 0;
        while (n < 500 && !flushed) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (flushed !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: got flushed=%b expected 1", flushed);
        end
        halt = 1'b0;
        checks++;
        if (log_we.size() != 3 + CNT_EN) begin
            failures++;
            $display("FAIL flush_traffic: got %0d transfers expected %0d", log_we.size(), 3 + CNT_EN);
        end else begin
            checks++;
            if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h80 || log_data[0] !== 32'h44444444) begin
                failures++;
                $display("FAIL flush_wb0: got addr=%h data=%h expected 00000080/44444444", log_addr[0], log_data[0]);
            end
            checks++;
            if (log_we[1] !== 1'b1 || log_addr[1] !== 32'h14 || log_data[1] !== 32'h55555555) begin
                failures++;
                $display("FAIL flush_wb5: got addr=%h data=%h expected 00000014/55555555", log_addr[1], log_data[1]);
            end
            checks++;
            if (log_we[2] !== 1'b1 || log_addr[2] !== 32'h3C || log_data[2] !== 32'h66666666) begin
                failures++;
                $display("FAIL flush_wb15: got addr=%h data=%h expected 0000003c/66666666", log_addr[2], log_data[2]);
            end
            if (CNT_EN == 1) begin
                checks++;
                if (log_we[3] !== 1'b1 || log_addr[3] !== 32'h3100 || log_data[3] !== 32'd2) begin
                    failures++;
                    $display("FAIL flush_count: got addr=%h data=%h expected 00003100/00000002",
                             log_addr[3], log_data[3]);
                end
            end
        end
    endtask

    task automatic test_done_hold();
        dmemREN = 1'b1;
        dmemWEN = 1'b1;
        dmemaddr = 32'h14;
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if ({dhit, dREN, dWEN, flushed} !== 4'b0001) begin
                failures++;
                $display("FAIL done_hold: got %b expected 0001", {dhit, dREN, dWEN, flushed});
            end
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        halt = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] rd;
        bit ok;
        bit seen;
        int cyc;
        @(negedge CLK);
        #2 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b1;
        lat = 50;
        @(posedge CLK);
        #1;
        dmemREN = 1'b1;
        dmemaddr = 32'h100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = dREN;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_fetch_start: got dREN=0 expected 1");
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (dREN !== 1'b0 || dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL abort_async: got dREN=%b state=%0d expected 0/%0d", dREN, dbg_state, S_IDLE);
        end
        dmemREN = 1'b0;
        repeat (2) @(negedge CLK);
        #2 nRST = 1'b1;
        lat = 1;
        mem[32'h100] = 32'h77777777;
        clear_log();
        access(1'b1, 1'b0, 32'h100, 32'h0, rd, ok, cyc);
        checks++;
        if (!ok || rd !== 32'h77777777) begin
            failures++;
            $display("FAIL abort_reread: got ok=%0d data=%h expected 1/77777777", ok, rd);
        end
        checks++;
        if (log_we.size() != 1 || cyc == 0) begin
            failures++;
            $display("FAIL abort_miss: got transfers=%0d cycles=%0d expected 1/nonzero", log_we.size(), cyc);
        end
    endtask

    task automatic test_halt_during_wb();
        logic [31:0] rd;
        logic [2:0]  seq[$];
        logic [2:0]  exp_seq[6];
        logic [2:0]  last;
        bit ok;
        bit seen;
        bit seq_ok;
        int cyc;
        access(1'b0, 1'b1, 32'h100, 32'h88888888, rd, ok, cyc);
        checks++;
        if (!ok || cyc != 0) begin
            failures++;
            $display("FAIL hwb_dirty_hit: got ok=%0d cycles=%0d expected 1/0", ok, cyc);
        end
        lat = 3;
        mem[32'h500] = 32'h99999999;
        clear_log();
        @(posedge CLK);
        #1;
        dmemREN = 1'b1;
        dmemaddr = 32'h500;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = dWEN;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL hwb_start: got dWEN=0 expected 1");
        end
        halt = 1'b1;
        seq.push_back(dbg_state);
        last = dbg_state;
        for (int i = 0; i < 300 && !flushed; i++) begin
            @(negedge CLK);
            if (dbg_state !== last) begin
                seq.push_back(dbg_state);
                last = dbg_state;
            end
        end
        halt = 1'b0;
        dmemREN = 1'b0;
        exp_seq = '{S_WB, S_FETCH, S_IDLE, S_FLUSH, S_COUNT, S_DONE};
        seq_ok = (seq.size() == 6);
        if (seq_ok) begin
            for (int i = 0; i < 6; i++) if (seq[i] !== exp_seq[i]) seq_ok = 1'b0;
        end
        checks++;
        if (!seq_ok) begin
            failures++;
            $display("FAIL hwb_states: got %0d states first=%0d expected WB,FETCH,IDLE,FLUSH,COUNT,DONE",
                     seq.size(), seq[0]);
        end
        checks++;
        if (log_we.size() != 2 + CNT_EN) begin
            failures++;
            $display("FAIL hwb_traffic: got %0d transfers expected %0d", log_we.size(), 2 + CNT_EN);
        end else begin
            checks++;
            if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h100 || log_data[0] !== 32'h88888888) begin
                failures++;
                $display("FAIL hwb_write: got addr=%h data=%h expected 00000100/88888888", log_addr[0], log_data[0]);
            end
            checks++;
            if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h500) begin
                failures++;
                $display("FAIL hwb_fetch: got we=%0d addr=%h expected 0/00000500", log_we[1], log_addr[1]);
            end
            if (CNT_EN == 1) begin
                checks++;
                if (log_addr[2] !== 32'h3100 || log_data[2] !== 32'h0) begin
                    failures++;
                    $display("FAIL hwb_count: got addr=%h data=%h expected 00003100/00000000",
                             log_addr[2], log_data[2]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_writeback();
        test_read_write_both();
        test_flush();
        test_done_hold();
        test_reset_mid_fetch();
        test_halt_during_wb();
        checks++;
        if (both_seen) begin
            failures++;
            $display("FAIL exclusive_req: got dREN and dWEN together expected never");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 The block SHALL have one parameter: SETS, default 16, meaning the number of direct-mapped one-word frames (power of 2, 2..256).
REQ-002 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have the port halt, input, 1 bit: datapath halt request; starts the flush.
REQ-005 The block SHALL have the port dmemREN, input, 1 bit: datapath read request.
REQ-006 The block SHALL have the port dmemWEN, input, 1 bit: datapath write request.
REQ-007 The block SHALL have the port dmemaddr, input, 32 bits: datapath byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have the port dmemstore, input, 32 bits: datapath write data.
REQ-009 The block SHALL have the port dmemload, output, 32 bits: read data, valid while dhit=1.
REQ-010 The block SHALL have the port dhit, output, 1 bit: the request completes this cycle.
REQ-011 The block SHALL have the port flushed, output, 1 bit: the flush is complete.
REQ-012 The block SHALL have the ports dREN and dWEN, outputs, 1 bit each: memory-controller read and write requests.
REQ-013 The block SHALL have the port daddr, output, 32 bits: memory word address, with bits [1:0]=00.
REQ-014 The block SHALL have the port dstore, output, 32 bits: memory write data.
REQ-015 The block SHALL have the port dload, input, 32 bits: memory read data.
REQ-016 The block SHALL have the port dwait, input, 1 bit: the memory transfer is not yet complete; dwait=0 completes the transfer in the current cycle.

Function
REQ-017 The address SHALL be split as: index = dmemaddr[2+log2(SETS)-1:2]; tag = the remaining upper bits. Each frame SHALL hold valid, dirty, tag and a 32-bit data word.
REQ-018 The state machine SHALL have the states IDLE, WB, FETCH, FLUSH, COUNT and DONE.
REQ-019 In IDLE, a request (REN or WEN) to a valid frame with a matching tag SHALL set dhit=1 combinationally in the same cycle.
REQ-020 On a read hit, dmemload SHALL equal the frame data.
REQ-021 On a write hit, the frame data SHALL take dmemstore and dirty SHALL be set at the clock edge.
REQ-022 If REN and WEN are both 1, the access SHALL be treated as a write.
REQ-023 In IDLE, a miss on a valid and dirty victim frame SHALL go to WB; any other miss SHALL go to FETCH.
REQ-024 In WB, the block SHALL drive dWEN=1, daddr={victim tag, index, 00} and dstore=victim data, and SHALL hold them until dwait=0, then go to FETCH.
REQ-025 In FETCH, the block SHALL drive dREN=1 and daddr={dmemaddr[31:2], 00}. On dwait=0 the frame SHALL be written with data=dload, tag=request tag, valid=1, dirty=0, and the state SHALL go to IDLE; the retried request then hits the next cycle.
REQ-026 dhit SHALL be 0 in every state except IDLE.
REQ-027 dREN and dWEN SHALL never both be 1.
REQ-028 halt=1 in IDLE SHALL take priority over any pending request: go to FLUSH with the flush index set to 0.
REQ-029 A halt asserted during WB or FETCH SHALL be honoured only after that transfer completes and the block returns to IDLE.
REQ-030 In FLUSH, a valid and dirty frame at the flush index SHALL be written back (dWEN=1, same addressing as WB) until dwait=0, then its dirty bit SHALL be cleared. A clean or invalid frame SHALL be skipped in one cycle with no memory request.
REQ-031 The flush index SHALL increment after each frame. After frame SETS-1 the state SHALL go to COUNT; the index SHALL NOT wrap into a second pass.
REQ-032 COUNT behaviour SHALL be as defined under Configuration.
REQ-033 DONE SHALL drive flushed=1, dREN=0, dWEN=0 and dhit=0, and SHALL hold until reset; halt and requests SHALL be ignored there.

Reset
REQ-034 While nRST=0, asynchronously: state=IDLE; every frame has valid=0 and dirty=0; flush index=0; hit counter=0.
REQ-035 While nRST=0, outputs SHALL be: dREN, dWEN, dhit and flushed = 0; daddr, dstore and dmemload = 0.
REQ-036 A reset during WB, FETCH or FLUSH SHALL abandon the transfer immediately, with no partial frame update.

Configuration
REQ-037 With DCACHE_HITCOUNT_EN defined, a signed 32-bit counter SHALL:
- increment on each IDLE cycle with dhit=1;
- decrement on each completed FETCH.
REQ-038 With DCACHE_HITCOUNT_EN defined, COUNT SHALL drive dWEN=1, daddr=0x00003100 and dstore=counter until dwait=0, then go to DONE.
REQ-039 Without DCACHE_HITCOUNT_EN, the counter SHALL be absent and COUNT SHALL go to DONE in one cycle with no memory request.

Verification
REQ-040 Cold read 0x00000040, dload=0xDEADBEEF, dwait=0 after 3 cycles -> one FETCH with daddr=0x40; then dhit=1 with dmemload=0xDEADBEEF.
REQ-041 Write 0x11111111 to 0x40 after REQ-040 -> immediate dhit, no memory traffic; then a read of 0x440 (SETS=16, same index) -> WB of 0x11111111 to 0x40, then FETCH of 0x440.
REQ-042 REN=WEN=1 to 0x80 on a clean miss -> FETCH only; the following hit writes the frame and sets it dirty.
REQ-043 Dirty frames at indices 0, 5 and 15, then halt -> exactly three writebacks in index order, then (macro on) a write to 0x3100 with dstore equal to the net hits, then flushed=1 held.
REQ-044 nRST pulsed low mid-FETCH with dwait=1 -> dREN drops asynchronously; the same address misses again after release.
REQ-045 halt asserted during a WB -> the WB completes, then FETCH, then IDLE, then FLUSH begins; the refilled word is not dirty and is not written back.
